// File: rtl/aq_axi_lite_master.sv
// rtl/aq_axi_lite_master.sv - single-outstanding AXI4-Lite master driven by a local request strobe
module aq_axi_lite_master #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        LOCAL_REQ,
  input  logic        LOCAL_RNW,
  input  logic [31:0] LOCAL_ADDR,
  input  logic [3:0]  LOCAL_BE,
  input  logic [31:0] LOCAL_WDATA,
  output logic        LOCAL_BUSY,
  output logic        LOCAL_ACK,
  output logic [31:0] LOCAL_RDATA,
  output logic [1:0]  LOCAL_RESP,
  output logic        LOCAL_TIMEOUT,
  output logic [31:0] M_AXI_AWADDR,
  output logic [3:0]  M_AXI_AWCACHE,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic [1:0]  M_AXI_BRESP,
  output logic [31:0] M_AXI_ARADDR,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  resp_q;
  logic [15:0] cnt_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, ack_q, timeout_q;
  logic        tmo_hit, aw_done, w_done;

  assign tmo_hit = (TIMEOUT != 16'd0) && (cnt_q == TIMEOUT - 16'd1);
  // A channel counts as done once its VALID is gone or it handshakes this cycle.
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q || M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      rdata_q   <= 32'h0;
      resp_q    <= 2'b00;
      cnt_q     <= 16'h0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (LOCAL_REQ) begin
            addr_q  <= LOCAL_ADDR;
            be_q    <= LOCAL_BE;
            wdata_q <= LOCAL_WDATA;
            if (LOCAL_RNW) begin
              arvalid_q <= 1'b1;
              state_q   <= S_RADDR;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WADDR;
            end
          end
        end
        S_WADDR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            cnt_q    <= 16'h0;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            resp_q    <= M_AXI_BRESP;
            timeout_q <= 1'b0;
            bready_q  <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= S_DONE;
          end else if (tmo_hit) begin
            resp_q    <= 2'b10;
            timeout_q <= 1'b1;
            bready_q  <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= 16'h0;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            rdata_q   <= M_AXI_RDATA;
            resp_q    <= M_AXI_RRESP;
            timeout_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= S_DONE;
          end else if (tmo_hit) begin
            rdata_q   <= 32'h0;
            resp_q    <= 2'b10;
            timeout_q <= 1'b1;
            rready_q  <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign LOCAL_BUSY    = (state_q != S_IDLE);
  assign LOCAL_ACK     = ack_q;
  assign LOCAL_RDATA   = rdata_q;
  assign LOCAL_RESP    = resp_q;
  assign LOCAL_TIMEOUT = timeout_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = be_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_aq_axi_lite_master.sv
// tb/tb_aq_axi_lite_master.sv - scoreboard bench for aq_axi_lite_master against a delay-programmable slave
module tb_aq_axi_lite_master;

  logic        aclk, aresetn;
  logic        local_req, local_rnw, local_busy, local_ack, local_timeout;
  logic [31:0] local_addr, local_wdata, local_rdata;
  logic [3:0]  local_be;
  logic [1:0]  local_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awcache, arcache, wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  aq_axi_lite_master #(.TIMEOUT(16'd8)) dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .LOCAL_REQ(local_req), .LOCAL_RNW(local_rnw), .LOCAL_ADDR(local_addr),
    .LOCAL_BE(local_be), .LOCAL_WDATA(local_wdata), .LOCAL_BUSY(local_busy),
    .LOCAL_ACK(local_ack), .LOCAL_RDATA(local_rdata), .LOCAL_RESP(local_resp),
    .LOCAL_TIMEOUT(local_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARADDR(araddr), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic        rnw;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [1:0]  resp;
    logic        to;
    int          lat, waitc;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0, n_fail = 0, req_cyc = 0;

  // Slave behaviour and observations for the current transaction.
  int cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_bresp, cfg_rresp;
  int aw_age, w_age, ar_age, b_age, r_age;
  bit aw_done, w_done, b_pend, r_pend;
  bit aw_prev, w_prev, ar_prev;
  int aw_cnt, w_cnt, ar_cnt, bready_cyc, rready_cyc, viol;
  logic [31:0] obs_awaddr, obs_wdata, obs_araddr;
  logic [3:0]  obs_wstrb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
        aw_prev = 0; w_prev = 0; ar_prev = 0;
      end else begin
        if ((aw_prev && !awvalid) || (w_prev && !wvalid) || (ar_prev && !arvalid)) viol++;
        aw_prev = awvalid && !awready;
        w_prev  = wvalid && !wready;
        ar_prev = arvalid && !arready;
        if (awvalid && awready) begin aw_cnt++; obs_awaddr = awaddr; aw_done = 1; aw_age = 0; end
        else if (awvalid) aw_age++;
        if (wvalid && wready) begin w_cnt++; obs_wdata = wdata; obs_wstrb = wstrb; w_done = 1; w_age = 0; end
        else if (wvalid) w_age++;
        if (aw_done && w_done) begin b_pend = 1; b_age = 0; aw_done = 0; w_done = 0; end
        else if (b_pend && !bvalid) b_age++;
        if (bvalid && bready) b_pend = 0;
        if (bready) bready_cyc++;
        if (arvalid && arready) begin ar_cnt++; obs_araddr = araddr; r_pend = 1; r_age = 0; ar_age = 0; end
        else begin
          if (arvalid) ar_age++;
          if (r_pend && !rvalid) r_age++;
        end
        if (rvalid && rready) r_pend = 0;
        if (rready) rready_cyc++;
      end
      @(posedge aclk); #1;
      awready = awvalid && (aw_age >= cfg_aw_dly);
      wready  = wvalid && (w_age >= cfg_w_dly);
      bvalid  = b_pend && (b_age >= cfg_b_dly);
      bresp   = cfg_bresp;
      arready = arvalid && (ar_age >= cfg_ar_dly);
      rvalid  = r_pend && (r_age >= cfg_r_dly);
      rdata   = rvalid ? cfg_rdata : 32'h0;
      rresp   = cfg_rresp;
    end
  end

  // Monitor: every ACK pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (local_ack) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_ack: got ack at cycle %0d, required none", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("ack_latency", cyc - req_cyc, e.lat);
          chk("rdata", local_rdata, e.rdata);
          chk("resp", {30'h0, local_resp}, {30'h0, e.resp});
          chk("timeout_flag", {31'h0, local_timeout}, {31'h0, e.to});
          chk("busy_at_ack", {31'h0, local_busy}, 32'h1);
          chk("ready_low_at_ack", {30'h0, bready, rready}, 32'h0);
          chk("valid_withdrawn", viol, 0);
          if (!e.rnw) begin
            chk("aw_handshakes", aw_cnt, 1);
            chk("w_handshakes", w_cnt, 1);
            chk("ar_handshakes", ar_cnt, 0);
            chk("awaddr", obs_awaddr, e.addr);
            chk("wdata", obs_wdata, e.wdata);
            chk("wstrb", {28'h0, obs_wstrb}, {28'h0, e.be});
            chk("bready_cycles", bready_cyc, e.waitc);
          end else begin
            chk("ar_handshakes", ar_cnt, 1);
            chk("aw_handshakes", aw_cnt + w_cnt, 0);
            chk("araddr", obs_araddr, e.addr);
            chk("rready_cycles", rready_cyc, e.waitc);
          end
        end
      end
    end
  end

  task automatic start(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int awd, input int wdly, input int bd,
                       input int ard, input int rd, input logic [31:0] sdata, input logic [1:0] sresp);
    cfg_aw_dly = awd; cfg_w_dly = wdly; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rd;
    cfg_rdata = sdata; cfg_bresp = sresp; cfg_rresp = sresp;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; bready_cyc = 0; rready_cyc = 0; viol = 0;
    b_pend = 0; r_pend = 0;
    local_req = 1; local_rnw = rnw; local_addr = addr; local_wdata = wd; local_be = be;
    req_cyc = cyc;
    @(posedge aclk); #1;
    local_addr = ~addr; local_wdata = ~wd; local_be = ~be;
    @(posedge aclk); #1;
    local_req = 0;
  endtask

  task automatic xact(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int awd, input int wdly, input int bd,
                      input int ard, input int rd, input logic [31:0] sdata, input logic [1:0] sresp,
                      input logic [31:0] e_rdata, input logic [1:0] e_resp, input logic e_to,
                      input int e_lat, input int e_wait);
    exp_t e;
    bit seen;
    e.rnw = rnw; e.addr = addr; e.wdata = wd; e.be = be; e.rdata = e_rdata;
    e.resp = e_resp; e.to = e_to; e.lat = e_lat; e.waitc = e_wait;
    sb_q.push_back(e);
    start(rnw, addr, wd, be, awd, wdly, bd, ard, rd, sdata, sresp);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge aclk);
      if (local_ack) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL ack_wait: got no ack within 100 cycles, required ack for addr 0x%08h", addr);
      void'(sb_q.pop_front());
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    aresetn = 0; local_req = 0; local_rnw = 0; local_addr = 0; local_wdata = 0; local_be = 0;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 1; cfg_ar_dly = 0; cfg_r_dly = 1;
    cfg_rdata = 0; cfg_bresp = 0; cfg_rresp = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; bready_cyc = 0; rready_cyc = 0; viol = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("rst_local", {29'h0, local_busy, local_ack, local_timeout}, 32'h0);
    chk("rst_rdata_resp", local_rdata | {30'h0, local_resp}, 32'h0);
    chk("cache_prot", {18'h0, awcache, awprot, arcache, arprot}, {18'h0, 4'b0011, 3'b000, 4'b0011, 3'b000});
    @(posedge aclk); #1;
    aresetn = 1;
    @(posedge aclk); #1;

    //   rnw addr          wdata         be    aw w  b     ar r     slave data    resp   e_rdata       e_resp e_to lat wait
    xact(0, 32'h0000_0000, 32'h8000_0000, 4'hF, 0, 0, 1,    0, 1,    32'h0,        2'b00, 32'h0,        2'b00, 0,   4, 2);
    xact(0, 32'h0000_0010, 32'h1234_5678, 4'h3, 3, 0, 1,    0, 1,    32'h0,        2'b11, 32'h0,        2'b11, 0,   7, 2);
    xact(0, 32'h0000_0014, 32'hCAFE_0001, 4'hC, 0, 2, 1,    0, 1,    32'h0,        2'b01, 32'h0,        2'b01, 0,   6, 2);
    xact(1, 32'h0000_0004, 32'h0,         4'h0, 0, 0, 1,    0, 4,    32'h01E0_0280, 2'b00, 32'h01E0_0280, 2'b00, 0,   7, 5);
    chk("rdata_held_idle", local_rdata, 32'h01E0_0280);
    xact(0, 32'h0000_0008, 32'hA5A5_0F0F, 4'h5, 0, 0, 1,    0, 1,    32'h0,        2'b00, 32'h01E0_0280, 2'b00, 0,   4, 2);
    xact(1, 32'h0000_000C, 32'h0,         4'h0, 0, 0, 1,    0, 1,    32'hDEAD_BEEF, 2'b10, 32'hDEAD_BEEF, 2'b10, 0,   4, 2);
    xact(0, 32'h0000_0020, 32'h5555_AAAA, 4'hF, 0, 0, 1000, 0, 1,    32'h0,        2'b00, 32'hDEAD_BEEF, 2'b10, 1,  10, 8);
    repeat (2) @(posedge aclk);
    #1;
    chk("bready_low_after_timeout", {31'h0, bready}, 32'h0);
    chk("timeout_held", {29'h0, local_timeout, local_resp}, 32'h6);
    xact(1, 32'h0000_0024, 32'h0,         4'h0, 0, 0, 1,    0, 1000, 32'h1111_2222, 2'b00, 32'h0,        2'b10, 1,  10, 8);
    xact(1, 32'h0000_002C, 32'h0,         4'h0, 0, 0, 1,    0, 1,    32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 2'b00, 0,   4, 2);

    // Reset while ARVALID is stuck high: the read is abandoned with no ACK.
    start(1, 32'h0000_0030, 32'h0, 4'h0, 0, 0, 1, 1000, 1, 32'h0, 2'b00);
    chk("arvalid_before_reset", {31'h0, arvalid}, 32'h1);
    #2 aresetn = 0;
    #1;
    chk("async_rst_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("async_rst_local", {29'h0, local_busy, local_ack, local_timeout}, 32'h0);
    chk("async_rst_rdata", local_rdata, 32'h0);
    chk("async_rst_resp", {30'h0, local_resp}, 32'h0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    @(posedge aclk); #1;
    xact(0, 32'h0000_0040, 32'h0000_00FF, 4'h1, 0, 0, 1,    0, 1,    32'h0,        2'b00, 32'h0,        2'b00, 0,   4, 2);

    repeat (3) @(posedge aclk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
